// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes on accept;
// 32 shift-add (multiply) or restoring (divide) steps follow, then a sign fix and an
// opcode select load the result register. Divide-by-zero and signed overflow bypass
// the iteration and finish in a single cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic        neg_a_q, neg_b_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] result_q;

  logic        a_signed, b_signed, in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] fast_res;

  // Accept-time decode: operand signedness, magnitudes and fast-path detection.
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    in_neg_a = a_signed & a[31];
    in_neg_b = b_signed & b[31];
    in_mag_a = in_neg_a ? (32'd0 - a) : a;
    in_mag_b = in_neg_b ? (32'd0 - b) : b;
    div_zero = funct3[2] && (b == 32'd0);
    div_ovf  = funct3[2] && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    fast_res = 32'd0;
    if (div_zero) begin
      fast_res = funct3[1] ? a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  logic [4:0]  bit_idx;
  logic [63:0] mul_add;
  logic [32:0] rem33, trial;
  logic [63:0] acc_nxt;
  logic [63:0] prod;
  logic [31:0] quot, rem, final_res;

  // One iteration step plus the sign fix / select used on the last step.
  always_comb begin
    bit_idx = 5'd31 - cnt_q[4:0];
    mul_add = mag_b_q[cnt_q[4:0]] ? ({32'd0, mag_a_q} << cnt_q[4:0]) : 64'd0;
    // Remainder in acc[63:32], quotient shifts into acc[31:0]; dividend bits come MSB-first.
    rem33   = {acc_q[63:32], mag_a_q[bit_idx]};
    trial   = rem33 - {1'b0, mag_b_q};
    if (op_q[2]) begin
      acc_nxt = trial[32] ? {rem33[31:0], acc_q[30:0], 1'b0}
                          : {trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_nxt = acc_q + mul_add;
    end
    prod = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_nxt) : acc_nxt;
    quot = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    rem  = neg_a_q ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];
    unique case (op_q)
      3'b000:                 final_res = prod[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod[63:32];
      3'b100, 3'b101:         final_res = quot;
      default:                final_res = rem;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      cnt_q    <= 6'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= funct3;
            neg_a_q <= in_neg_a;
            neg_b_q <= in_neg_b;
            mag_a_q <= in_mag_a;
            mag_b_q <= in_mag_b;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            if (div_zero || div_ovf) begin
              result_q <= fast_res;
              state_q  <= StDone;
            end else begin
              state_q  <= StRun;
            end
          end
        end
        StRun: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_q <= final_res;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
